// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Shared types for the ALU interrupt responder: handler FSM
//                states, interrupt source tags and the event record stored in
//                the event FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // ALU result byte
  typedef logic [7:0] data_t;

  // Interrupt handler FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    WAIT_LOW = 2'd2
  } irq_hdl_state_t;

  // Which ALU enable path was active when the interrupt was taken
  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_A    = 2'b01,
    SRC_B    = 2'b10,
    SRC_BOTH = 2'b11
  } irq_src_t;

  // One captured interrupt event
  typedef struct packed {
    data_t    data;
    irq_src_t src;
  } alu_evt_t;

  // The tag encoding is chosen so that bit 0 mirrors enable A and bit 1
  // mirrors enable B; the four cases collapse to a simple concatenation.
  function automatic irq_src_t src_tag(input logic en_a, input logic en_b);
    return irq_src_t'({en_b, en_a});
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_irq_handler_if.sv
`default_nettype none
// ============================================================================
//  Interface   : alu_irq_handler_if
//  Description : Event stream from the interrupt handler to its consumer.
//                valid/ready handshake, head-of-FIFO payload and occupancy.
//  Revision    : 1.0  initial release
//  Signals     : evt_valid  - FIFO not empty
//                evt_data   - captured ALU result at the FIFO head
//                evt_src    - source tag at the FIFO head
//                evt_level  - FIFO occupancy ($clog2(DEPTH)+1 bits)
//                evt_ready  - consumer pops on evt_valid && evt_ready
//  Modports    : master - the handler (drives the payload)
//                slave  - the consumer (drives evt_ready)
// ============================================================================
interface alu_irq_handler_if
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic                   evt_valid;
  data_t                  evt_data;
  irq_src_t               evt_src;
  logic [$clog2(DEPTH):0] evt_level;
  logic                   evt_ready;

  modport master (
    output evt_valid,
    output evt_data,
    output evt_src,
    output evt_level,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    input  evt_src,
    input  evt_level,
    output evt_ready
  );

endinterface : alu_irq_handler_if
`default_nettype wire

// File: rtl/alu_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_evt_fifo
//  Description : First-word fall-through FIFO of alu_evt_t records. The head
//                entry is presented combinationally from the storage array.
//                The caller must not push when full unless it also pops in
//                the same cycle; simultaneous push and pop leave the level
//                unchanged.
//  Revision    : 1.0  initial release
//  Parameters  : DEPTH    - number of entries, power of 2, >= 2
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-low reset
//                push     - write push_evt at the tail
//                push_evt - record to write
//                pop      - remove the head entry (ignored when empty)
//                head_evt - record at the head (undefined when empty)
//                full     - level == DEPTH
//                empty    - level == 0
//                level    - number of stored entries
// ============================================================================
module alu_evt_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  alu_evt_t               push_evt,
  input  logic                   pop,
  output alu_evt_t               head_evt,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_LEVEL = (AW+1)'(DEPTH);

  alu_evt_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_rd;

  assign w_rd     = pop && (r_level != '0);
  assign full     = (r_level == C_FULL_LEVEL);
  assign empty    = (r_level == '0);
  assign level    = r_level;
  assign head_evt = r_mem[r_rd_ptr];

  // Storage carries no reset; the head is only meaningful while not empty.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_evt;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule : alu_evt_fifo
`default_nettype wire

// File: rtl/alu_irq_handler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_irq_handler
//  Description : Interrupt responder for the ALU. On a sampled alu_irq in IDLE
//                it captures alu_out plus an enable-path source tag into an
//                event FIFO, pulses alu_irq_clr for CLR_CYCLES cycles, then
//                waits for alu_irq to drop before re-arming.
//  Revision    : 1.0  initial release
//  Parameters  : DEPTH      - event FIFO entries, power of 2, >= 2
//                CLR_CYCLES - alu_irq_clr pulse width, 1..15
//                TIMEOUT    - WAIT_LOW cycles with alu_irq high before a
//                             re-pulse, 2..255 (timeout build only)
//  Macro       : ALU_IRQ_TIMEOUT_EN - when defined, WAIT_LOW times out,
//                sets sts_err and re-enters CLEAR; when undefined WAIT_LOW
//                waits indefinitely and sts_err is tied low.
//  Ports       : clk          - clock, rising edge
//                alu_rst_n    - asynchronous active-low reset
//                alu_irq      - ALU interrupt, level
//                alu_out      - ALU result
//                alu_enable_a - path-A enable (source tagging)
//                alu_enable_b - path-B enable (source tagging)
//                alu_irq_clr  - interrupt clear pulse to the ALU
//                evt_cnt      - accepted events, saturating at 8'hFF
//                sts_ovf      - sticky: an event was dropped on a full FIFO
//                sts_err      - sticky: clear timeout
//                sts_clr      - synchronous clear of sts_ovf/sts_err/evt_cnt
//                evt          - event stream (master modport)
// ============================================================================
module alu_irq_handler
  import alu_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       alu_rst_n,
  input  logic                       alu_irq,
  input  data_t                      alu_out,
  input  logic                       alu_enable_a,
  input  logic                       alu_enable_b,
  output logic                       alu_irq_clr,
  output logic [7:0]                 evt_cnt,
  output logic                       sts_ovf,
  output logic                       sts_err,
  input  logic                       sts_clr,
  alu_irq_handler_if.master          evt
);

  localparam logic [3:0] C_CLR_CYCLES = 4'(CLR_CYCLES);

  irq_hdl_state_t          r_state;
  logic [3:0]              r_clr_cnt;

  alu_evt_t                w_new_evt;
  alu_evt_t                w_head_evt;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_level;
  logic                    w_capture;
  logic                    w_pop;
  logic                    w_accept;
  logic                    w_drop;

  // --------------------------------------------------------------------------
  // Capture / push decision
  // --------------------------------------------------------------------------
  // Only the IDLE->CLEAR transition captures, so re-pulses never add events.
  assign w_capture = (r_state == IDLE) && alu_irq;
  assign w_pop     = !w_empty && evt.evt_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign w_accept  = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  assign w_new_evt = '{data: alu_out, src: src_tag(alu_enable_a, alu_enable_b)};

  alu_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk      (clk),
    .rst_n    (alu_rst_n),
    .push     (w_accept),
    .push_evt (w_new_evt),
    .pop      (w_pop),
    .head_evt (w_head_evt),
    .full     (w_full),
    .empty    (w_empty),
    .level    (w_level)
  );

  // Payload is forced to zero while empty so the stream reads clean after
  // reset and between events.
  assign evt.evt_valid = !w_empty;
  assign evt.evt_data  = w_empty ? '0 : w_head_evt.data;
  assign evt.evt_src   = w_empty ? SRC_NONE : w_head_evt.src;
  assign evt.evt_level = w_level;

  // --------------------------------------------------------------------------
  // Event counter and overflow status
  // --------------------------------------------------------------------------
  // sts_clr wins over a same-cycle increment or overflow set.
  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      evt_cnt <= 8'h00;
      sts_ovf <= 1'b0;
    end else if (sts_clr) begin
      evt_cnt <= 8'h00;
      sts_ovf <= 1'b0;
    end else begin
      if (w_accept && (evt_cnt != 8'hFF)) begin
        evt_cnt <= evt_cnt + 8'd1;
      end
      if (w_drop) begin
        sts_ovf <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handler FSM
  // --------------------------------------------------------------------------
`ifdef ALU_IRQ_TIMEOUT_EN
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_to_cnt;
  logic       r_err;
  assign sts_err = r_err;
`else
  assign sts_err = 1'b0;
`endif

  // The clear pulse is registered one cycle after the capture edge: the
  // capture edge moves to CLEAR with alu_irq_clr still low, then CLEAR
  // raises it for CLR_CYCLES edges and drops it on the edge that enters
  // WAIT_LOW.
  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      r_state     <= IDLE;
      alu_irq_clr <= 1'b0;
      r_clr_cnt   <= 4'd0;
`ifdef ALU_IRQ_TIMEOUT_EN
      r_to_cnt    <= 8'd0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          alu_irq_clr <= 1'b0;
          if (alu_irq) begin
            r_state   <= CLEAR;
            r_clr_cnt <= 4'd0;
          end
        end

        CLEAR: begin
          if (r_clr_cnt < C_CLR_CYCLES) begin
            alu_irq_clr <= 1'b1;
            r_clr_cnt   <= r_clr_cnt + 4'd1;
          end else begin
            alu_irq_clr <= 1'b0;
            r_state     <= WAIT_LOW;
`ifdef ALU_IRQ_TIMEOUT_EN
            r_to_cnt    <= 8'd0;
`endif
          end
        end

        WAIT_LOW: begin
          alu_irq_clr <= 1'b0;
          if (!alu_irq) begin
            r_state <= IDLE;
          end
`ifdef ALU_IRQ_TIMEOUT_EN
          // The TIMEOUT-th high cycle re-pulses without a new capture.
          else if (r_to_cnt == C_TIMEOUT_LAST) begin
            r_err     <= 1'b1;
            r_state   <= CLEAR;
            r_clr_cnt <= 4'd0;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
`endif
        end

        default: begin
          alu_irq_clr <= 1'b0;
          r_state     <= IDLE;
        end
      endcase

`ifdef ALU_IRQ_TIMEOUT_EN
      // Last assignment wins: sts_clr overrides a same-cycle timeout set.
      if (sts_clr) begin
        r_err <= 1'b0;
      end
`endif
    end
  end

endmodule : alu_irq_handler
`default_nettype wire

// File: tb/tb_alu_irq_handler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_irq_handler
//  Description : Self-checking bench for alu_irq_handler. A queue-based
//                reference model predicts every output each cycle; directed
//                sequences and a source-tag table add explicit checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_irq_handler;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CLR   = 2;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       irq;
  data_t      out;
  logic       en_a;
  logic       en_b;
  logic       clr;
  logic [7:0] cnt;
  logic       ovf;
  logic       err;
  logic       sclr;

  alu_irq_handler_if #(.DEPTH(DEPTH)) evt_if ();

  alu_irq_handler #(
    .DEPTH      (DEPTH),
    .CLR_CYCLES (CLR),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .alu_rst_n    (rst_n),
    .alu_irq      (irq),
    .alu_out      (out),
    .alu_enable_a (en_a),
    .alu_enable_b (en_b),
    .alu_irq_clr  (clr),
    .evt_cnt      (cnt),
    .sts_ovf      (ovf),
    .sts_err      (err),
    .sts_clr      (sclr),
    .evt          (evt_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Event queue of {data, src}; the clear sequence is tracked as "cycles
  // since the pulse started" plus a waiting flag.
  logic [9:0] mq[$];
  int  m_cnt;
  bit  m_ovf, m_err, m_clr;
  bit  m_busy;     // not able to capture
  bit  m_waiting;  // pulse done, waiting for irq low
  int  m_age;      // edges since the pulse sequence (re)started
  int  m_hi;       // high cycles seen while waiting
  int  pulses;
  int  hi_cycles;
  bit  prev_clr;

  function automatic void m_reset();
    mq.delete();
    m_cnt = 0; m_ovf = 0; m_err = 0; m_clr = 0;
    m_busy = 0; m_waiting = 0; m_age = 0; m_hi = 0;
  endfunction

  function automatic void model_update(bit i_irq, data_t i_out, bit i_a, bit i_b,
                                       bit i_rdy, bit i_sclr);
    bit pop, cap, acc, tmo;
    logic [1:0] s;
    pop = (mq.size() > 0) && i_rdy;
    cap = !m_busy && i_irq;
    acc = cap && ((mq.size() < DEPTH) || pop);
    s   = 2'(int'(i_a) + 2 * int'(i_b));
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back({i_out, s});
    if (i_sclr) begin
      m_cnt = 0; m_ovf = 0;
    end else begin
      if (acc && m_cnt < 255) m_cnt++;
      if (cap && !acc) m_ovf = 1;
    end
    tmo = 0;
    if (!m_busy) begin
      m_clr = 0;
      if (i_irq) begin m_busy = 1; m_waiting = 0; m_age = 0; end
    end else if (!m_waiting) begin
      m_age++;
      // clear is high for ages 1..CLR, the next edge starts waiting
      m_clr = (m_age <= CLR);
      if (m_age == CLR + 1) begin m_waiting = 1; m_hi = 0; end
    end else begin
      m_clr = 0;
      if (!i_irq) m_busy = 0;
      else begin
`ifdef ALU_IRQ_TIMEOUT_EN
        m_hi++;
        if (m_hi == TMO) begin tmo = 1; m_waiting = 0; m_age = 0; end
`endif
      end
    end
    if (i_sclr) m_err = 0;
    else if (tmo) m_err = 1;
  endfunction

  function automatic logic [7:0] exp_data();
    logic [9:0] h;
    if (mq.size() == 0) return 8'h00;
    h = mq[0];
    return h[9:2];
  endfunction

  function automatic logic [1:0] exp_src();
    logic [9:0] h;
    if (mq.size() == 0) return 2'b00;
    h = mq[0];
    return h[1:0];
  endfunction

  task automatic check_all();
    check("clr",   clr, m_clr);
    check("valid", evt_if.evt_valid, mq.size() > 0);
    check("data",  evt_if.evt_data, exp_data());
    check("src",   evt_if.evt_src, exp_src());
    check("level", evt_if.evt_level, mq.size());
    check("cnt",   cnt, m_cnt);
    check("ovf",   ovf, m_ovf);
    check("err",   err, m_err);
  endtask

  // Drive at negedge, let one posedge happen, compare at the next negedge.
  task automatic step(bit i_irq, data_t i_out, bit i_a, bit i_b, bit i_rdy, bit i_sclr);
    irq = i_irq; out = i_out; en_a = i_a; en_b = i_b;
    evt_if.evt_ready = i_rdy; sclr = i_sclr;
    model_update(i_irq, i_out, i_a, i_b, i_rdy, i_sclr);
    @(posedge clk);
    @(negedge clk);
    if (clr && !prev_clr) pulses++;
    if (clr) hi_cycles++;
    prev_clr = clr;
    check_all();
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  // One-cycle interrupt, then enough quiet cycles to return to IDLE.
  task automatic irq_once(data_t d, bit a, bit b);
    step(1, d, a, b, 0, 0);
    idle(CLR + 2);
  endtask

  typedef struct {
    data_t      d;
    bit         a;
    bit         b;
    logic [1:0] src;
  } vec_t;

  vec_t  tbl[4];
  data_t ovf_list[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h3C, 1'b0, 1'b0, 2'b00};
    tbl[1] = '{8'hA5, 1'b1, 1'b0, 2'b01};
    tbl[2] = '{8'h5A, 1'b0, 1'b1, 2'b10};
    tbl[3] = '{8'h81, 1'b1, 1'b1, 2'b11};
    ovf_list[0] = 8'hF1; ovf_list[1] = 8'hF4; ovf_list[2] = 8'hF5;
    ovf_list[3] = 8'hFF; ovf_list[4] = 8'h00;

    // ---------------- reset ----------------
    rst_n = 1'b0; irq = 0; out = 0; en_a = 0; en_b = 0; sclr = 0;
    evt_if.evt_ready = 0;
    m_reset(); pulses = 0; hi_cycles = 0; prev_clr = 0;
    repeat (2) @(negedge clk);
    check("rst_clr",   clr, 0);
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_data",  evt_if.evt_data, 0);
    check("rst_level", evt_if.evt_level, 0);
    check("rst_cnt",   cnt, 0);
    check("rst_ovf",   ovf, 0);
    check("rst_err",   err, 0);
    rst_n = 1'b1;
    idle(2);

    // ---------------- basic interrupt ----------------
    pulses = 0; hi_cycles = 0;
    step(1, 8'hF8, 1, 0, 0, 0);
    check("basic_valid_after_N", evt_if.evt_valid, 1);
    check("basic_clr_at_N", clr, 0);
    step(1, 8'h00, 1, 0, 0, 0);
    check("basic_clr_N1", clr, 1);
    step(1, 8'h00, 1, 0, 0, 0);
    check("basic_clr_N2", clr, 1);
    step(0, 8'h00, 0, 0, 0, 0);
    check("basic_clr_N3", clr, 0);
    idle(3);
    check("basic_data", evt_if.evt_data, 8'hF8);
    check("basic_src",  evt_if.evt_src, 2'b01);
    check("basic_cnt",  cnt, 1);
    check("basic_pulses", pulses, 1);
    check("basic_width",  hi_cycles, CLR);
    step(0, 8'h00, 0, 0, 1, 0);
    check("basic_popped", evt_if.evt_valid, 0);

    // ---------------- source-tag table ----------------
    for (int i = 0; i < 4; i++) begin
      irq_once(tbl[i].d, tbl[i].a, tbl[i].b);
      check("tbl_data", evt_if.evt_data, tbl[i].d);
      check("tbl_src",  evt_if.evt_src, tbl[i].src);
      step(0, 8'h00, 0, 0, 1, 0);
    end

    // ---------------- overflow ----------------
    step(0, 8'h00, 0, 0, 0, 1);
    check("sclr_cnt", cnt, 0);
    pulses = 0;
    for (int i = 0; i < 5; i++) irq_once(ovf_list[i], 1, 0);
    check("ovf_level",  evt_if.evt_level, 4);
    check("ovf_flag",   ovf, 1);
    check("ovf_pulses", pulses, 5);
    check("ovf_cnt",    cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", evt_if.evt_data, ovf_list[i]);
      step(0, 8'h00, 0, 0, 1, 0);
    end
    check("drain_empty", evt_if.evt_level, 0);

    // ---------------- full with same-cycle pop ----------------
    step(0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) irq_once(data_t'(8'h10 + i), 0, 0);
    check("full_level", evt_if.evt_level, 4);
    step(1, 8'h99, 0, 1, 1, 0);
    check("fullpop_level", evt_if.evt_level, 4);
    check("fullpop_ovf",   ovf, 0);
    check("fullpop_cnt",   cnt, 5);
    check("fullpop_head",  evt_if.evt_data, 8'h11);
    idle(CLR + 2);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1, 0);
    check("fullpop_tail_data", evt_if.evt_data, 8'h99);
    check("fullpop_tail_src",  evt_if.evt_src, 2'b10);
    step(0, 8'h00, 0, 0, 1, 0);

    // ---------------- long interrupt / timeout ----------------
    step(0, 8'h00, 0, 0, 0, 1);
    pulses = 0;
    repeat (40) step(1, 8'h77, 1, 1, 0, 0);
    idle(CLR + 4);
    check("long_level", evt_if.evt_level, 1);
    check("long_cnt",   cnt, 1);
`ifdef ALU_IRQ_TIMEOUT_EN
    check("tmo_err", err, 1);
    check("tmo_repulse", pulses >= 2, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    check("tmo_err_cleared", err, 0);
`else
    check("notmo_err", err, 0);
    check("notmo_pulses", pulses, 1);
`endif
    step(0, 8'h00, 0, 0, 1, 0);

    // ---------------- reset during CLEAR ----------------
    step(1, 8'h42, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    check("pre_rst_clr", clr, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_clr",   clr, 0);
    check("rst_mid_valid", evt_if.evt_valid, 0);
    check("rst_mid_level", evt_if.evt_level, 0);
    m_reset(); prev_clr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    idle(4);
    check("post_rst_no_pulse", pulses, 0);
    step(1, 8'h24, 1, 0, 0, 0);
    check("post_rst_capture", evt_if.evt_valid, 1);
    idle(CLR + 2);
    step(0, 8'h00, 0, 0, 1, 0);

    // ---------------- randomized ----------------
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, data_t'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_alu_irq_handler
`default_nettype wire

// File: doc/alu_irq_handler.md
# alu_irq_handler

Interrupt responder for the ALU: consumes `alu_irq` and `alu_out` and drives `alu_irq_clr` back with a fixed-width clear pulse. Each interrupt's result byte and enable-path source tag go into a small event FIFO, which a downstream consumer drains with a valid/ready handshake. The block sits beside the ALU on the same clock as the master that owns `alu_enable_a/b`.

## Interface
Parameters:
- `DEPTH`, 4, event FIFO entries; power of 2, ≥2
- `CLR_CYCLES`, 2, `alu_irq_clr` pulse width in cycles; 1..15
- `TIMEOUT`, 16, cycles to wait for `alu_irq` to drop after a clear; 2..255

Ports:
- `clk` in 1: single clock, rising edge
- `alu_rst_n` in 1: asynchronous, active-low reset
- `alu_irq` in 1: ALU interrupt, level
- `alu_out` in 8: ALU result
- `alu_enable_a` in 1: path-A enable, used for source tagging
- `alu_enable_b` in 1: path-B enable, used for source tagging
- `alu_irq_clr` out 1: interrupt clear to the ALU
- `evt_valid` out 1: FIFO not empty
- `evt_data` out 8: captured `alu_out` at the FIFO head
- `evt_src` out 2: source tag at the FIFO head
- `evt_ready` in 1: consumer pops on `evt_valid && evt_ready`
- `evt_level` out $clog2(DEPTH)+1: FIFO occupancy
- `evt_cnt` out 8: accepted events, saturating at 8'hFF
- `sts_ovf` out 1: sticky; an event was dropped because the FIFO was full
- `sts_err` out 1: sticky; clear timeout (macro-dependent)
- `sts_clr` in 1: synchronous clear of `sts_ovf`, `sts_err`, `evt_cnt`

## Operation
- FSM states: IDLE, CLEAR, WAIT_LOW.
- **IDLE, `alu_irq`=1 sampled:**
  - Capture `alu_out` and the source tag.
  - Push the capture to the FIFO; go to CLEAR.
- **Source tag:**
  - 2'b01 if `alu_enable_a && !alu_enable_b`
  - 2'b10 if `alu_enable_b && !alu_enable_a`
  - 2'b11 if both are high
  - 2'b00 if neither is high
- **CLEAR:**
  - `alu_irq_clr`=1 for exactly CLR_CYCLES cycles, counted by `clr_cnt`.
  - Then go to WAIT_LOW.
- **WAIT_LOW:**
  - `alu_irq_clr`=0.
  - `alu_irq`=0 sampled: go to IDLE.
- **Events per interrupt:** exactly one event per IDLE→CLEAR transition. Re-pulses never capture.
- **FIFO:**
  - First-word fall-through.
  - Push and pop in the same cycle: both occur and the level is unchanged.
  - Full, with no pop that cycle: the push is dropped, `sts_ovf` is set, and the clear sequence still runs.
  - Full with a pop in the same cycle: the push is accepted.
- **`evt_cnt`:** increments on every accepted push; holds at FF.
- **`sts_clr` priority:** `sts_clr` beats a same-cycle set, so the bit reads 0 on the next cycle. An `evt_cnt` increment in the same cycle is also lost.
- **Reset:** an asynchronous assert mid-sequence aborts immediately.

## Timing
- Reset values:
  - FSM: IDLE
  - Outputs: `alu_irq_clr`=0, `evt_valid`=0, `evt_data`=0, `evt_src`=0, `evt_level`=0, `evt_cnt`=0, `sts_ovf`=0, `sts_err`=0
  - FIFO pointers and `clr_cnt`: 0
- All outputs are registered, or derived combinationally from registered FIFO state.
- Interrupt latency, with `alu_irq` sampled high at edge N:
  - `evt_valid` high after edge N, if the FIFO was empty.
  - `alu_irq_clr` high from edge N+1 through edge N+CLR_CYCLES, low after edge N+1+CLR_CYCLES.
- Minimum IDLE-to-IDLE time: CLR_CYCLES+2 cycles, reached when `alu_irq` drops during the pulse.
- Pop: takes effect on the edge where `evt_valid && evt_ready`. The next head is visible after that edge.

## Configuration
- Macro: `ALU_IRQ_TIMEOUT_EN`.
- Defined:
  - WAIT_LOW counts cycles with `alu_irq`=1.
  - At TIMEOUT the block sets `sts_err` and re-enters CLEAR to re-pulse, with no new capture.
  - The counter resets on every WAIT_LOW entry.
- Undefined:
  - WAIT_LOW waits indefinitely.
  - `sts_err` is tied to 0 and no timeout counter is synthesized.

## Structure
- `alu_pkg` gains:
  - `irq_hdl_state_t`: enum IDLE/CLEAR/WAIT_LOW
  - `irq_src_t`: enum SRC_NONE/SRC_A/SRC_B/SRC_BOTH
  - `alu_evt_t`: packed struct of `data_t` result and `irq_src_t`
- Sub-module `alu_evt_fifo`: parameterized by DEPTH, stores `alu_evt_t`, and provides push/pop/full/empty/level. Instantiated once.
- The FSM, clear counter, timeout counter and status bits live in `alu_irq_handler`.

## Test plan
- Reset, then `alu_irq`=1 with `alu_out`=8'hF8 and `alu_enable_a`=1; `alu_irq` drops after the pulse.
  - `evt_data`=F8, `evt_src`=01, `evt_cnt`=1.
  - `alu_irq_clr` high for exactly 2 cycles starting N+1.
- With `evt_ready`=0, DEPTH=4, five interrupts whose results are F1, F4, F5, FF, 00.
  - `evt_level`=4 and `sts_ovf`=1.
  - Drain order F1, F4, F5, FF.
  - 5 clear pulses issued; `evt_cnt`=4.
- With the FIFO full, `evt_ready`=1 in the same cycle as an interrupt capture.
  - Push accepted, `sts_ovf` stays 0, level stays 4.
- `ALU_IRQ_TIMEOUT_EN` defined; hold `alu_irq`=1 for 40 cycles with TIMEOUT=16.
  - `sts_err`=1 and a second clear pulse appears; only one event is captured.
  - `sts_clr` then gives `sts_err`=0.
- Assert `alu_rst_n`=0 during CLEAR.
  - `alu_irq_clr`=0 immediately and FIFO empty.
  - After release with `alu_irq`=0, the FSM stays in IDLE.
